// File: rtl/sync_pulse_gen.sv
// -----------------------------------------------------------------------------
// sync_pulse_gen
//
// Programmable strobe generator in the clkin domain. It feeds the sin input of
// a downstream pulse_synchronizer. A run is launched by a start command. Each
// run is a start delay followed by a train of single-cycle pulses at a
// programmable period. The period is clamped up to pMIN_GAP. This clamp keeps
// consecutive pulses from arriving faster than the synchronizer's level/feedback
// round trip can clear.
//
// Optional feature (compile-time macro):
//   SYNC_PULSE_GEN_RETRIG_EN
//     Defined   : a start seen while busy (and stop low) restarts the run. Config
//                 is re-latched, pulse_idx is cleared, and the interrupted run
//                 reports neither done nor aborted. start_ignored stays 0.
//     Undefined : a start seen while busy is dropped, and start_ignored pulses.
//
// Parameters:
//   pCNT_W   - width of cfg_delay, cfg_period, cfg_count and pulse_idx
//   pMIN_GAP - minimum clkin cycles between pulses (1 .. 2**pCNT_W-1)
//
// Ports:
//   clkin         in   clock
//   resetin       in   asynchronous, active-high reset
//   start         in   run request, sampled every clkin edge
//   stop          in   abort request, sampled every clkin edge (wins over start)
//   cfg_delay     in   cycles from accepted start to first pulse (D)
//   cfg_period    in   requested pulse spacing (P), clamped to >= pMIN_GAP
//   cfg_count     in   pulses per run (N); 0 = run until stop
//   pulse_out     out  registered single-cycle strobe
//   busy          out  run in progress
//   done          out  1-cycle pulse, run completed normally
//   aborted       out  1-cycle pulse, run ended by stop
//   start_ignored out  1-cycle pulse, start rejected while busy
//   pulse_idx     out  pulses emitted in the current/last run
// -----------------------------------------------------------------------------
module sync_pulse_gen #(
    parameter int unsigned pCNT_W   = 16,
    parameter int unsigned pMIN_GAP = 8
) (
    input  logic              clkin,
    input  logic              resetin,
    input  logic              start,
    input  logic              stop,
    input  logic [pCNT_W-1:0] cfg_delay,
    input  logic [pCNT_W-1:0] cfg_period,
    input  logic [pCNT_W-1:0] cfg_count,
    output logic              pulse_out,
    output logic              busy,
    output logic              done,
    output logic              aborted,
    output logic              start_ignored,
    output logic [pCNT_W-1:0] pulse_idx
);

`ifdef SYNC_PULSE_GEN_RETRIG_EN
    localparam bit cRetrig = 1'b1;
`else
    localparam bit cRetrig = 1'b0;
`endif

    localparam logic [pCNT_W-1:0] cMinGap = pCNT_W'(pMIN_GAP);
    localparam logic [pCNT_W-1:0] cOne    = pCNT_W'(1);

    typedef enum logic [1:0] {
        StIdle  = 2'd0,
        StDelay = 2'd1,
        StRun   = 2'd2
    } state_t;

    // ---------------------------------------------------------------------
    // State and registered outputs
    // ---------------------------------------------------------------------
    state_t            r_state;
    logic [pCNT_W-1:0] r_cnt;      // shared down-counter: start delay, then gap
    logic [pCNT_W-1:0] r_period;   // latched effective period (Peff)
    logic [pCNT_W-1:0] r_count;    // latched N
    logic [pCNT_W-1:0] r_idx;
    logic              r_pulse;
    logic              r_done;
    logic              r_aborted;
    logic              r_start_ignored;

    state_t            w_state_nxt;
    logic [pCNT_W-1:0] w_cnt_nxt;
    logic [pCNT_W-1:0] w_period_nxt;
    logic [pCNT_W-1:0] w_count_nxt;
    logic [pCNT_W-1:0] w_idx_nxt;
    logic              w_pulse_nxt;
    logic              w_done_nxt;
    logic              w_aborted_nxt;
    logic              w_ign_nxt;

    logic [pCNT_W-1:0] w_peff;
    logic [pCNT_W-1:0] w_idx_inc;
    logic              w_last;
    logic              w_accept;

    // Effective period for a run that would be accepted this cycle.
    assign w_peff    = (cfg_period < cMinGap) ? cMinGap : cfg_period;
    assign w_idx_inc = r_idx + cOne;

    // pulse_idx counts a pulse in the cycle it is visible on pulse_out. So the
    // Nth pulse is recognised one edge after it was registered, and that edge
    // is the one that completes the run.
    assign w_last = r_pulse && (r_count != '0) && (w_idx_inc == r_count);

    // ---------------------------------------------------------------------
    // Next-state / output logic
    // ---------------------------------------------------------------------
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_period_nxt  = r_period;
        w_count_nxt   = r_count;
        w_idx_nxt     = r_pulse ? w_idx_inc : r_idx;  // wraps silently when N=0
        w_pulse_nxt   = 1'b0;
        w_done_nxt    = 1'b0;
        w_aborted_nxt = 1'b0;
        w_ign_nxt     = 1'b0;
        w_accept      = 1'b0;

        case (r_state)
            StIdle: begin
                // stop wins over a simultaneous start; nothing is reported
                if (start && !stop) begin
                    w_accept = 1'b1;
                end
            end

            StDelay, StRun: begin
                if (stop) begin
                    // stop suppresses any pulse due on this edge
                    w_state_nxt   = StIdle;
                    w_aborted_nxt = 1'b1;
                end else if (start && cRetrig) begin
                    w_accept = 1'b1;
                end else begin
                    // Gate on the previous value so a held start cannot
                    // produce back-to-back start_ignored strobes.
                    if (start) begin
                        w_ign_nxt = !r_start_ignored;
                    end

                    if (r_state == StDelay) begin
                        if (r_cnt == '0) begin
                            w_pulse_nxt = 1'b1;
                            w_cnt_nxt   = r_period - cOne;
                            w_state_nxt = StRun;
                        end else begin
                            w_cnt_nxt = r_cnt - cOne;
                        end
                    end else begin
                        if (w_last) begin
                            w_state_nxt = StIdle;
                            w_done_nxt  = 1'b1;
                        end else if (r_cnt == '0) begin
                            w_pulse_nxt = 1'b1;
                            w_cnt_nxt   = r_period - cOne;
                        end else begin
                            w_cnt_nxt = r_cnt - cOne;
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = StIdle;
            end
        endcase

        // Accepting a run (fresh or retrigger). With D=0 the first pulse is
        // registered on the accept edge itself, so the delay state is skipped.
        // Otherwise the counter holds D-1 so that the pulse lands D edges later.
        if (w_accept) begin
            w_period_nxt = w_peff;
            w_count_nxt  = cfg_count;
            w_idx_nxt    = '0;
            if (cfg_delay == '0) begin
                w_pulse_nxt = 1'b1;
                w_cnt_nxt   = w_peff - cOne;
                w_state_nxt = StRun;
            end else begin
                w_cnt_nxt   = cfg_delay - cOne;
                w_state_nxt = StDelay;
            end
        end
    end

    always_ff @(posedge clkin or posedge resetin) begin
        if (resetin) begin
            r_state         <= StIdle;
            r_cnt           <= '0;
            r_period        <= '0;
            r_count         <= '0;
            r_idx           <= '0;
            r_pulse         <= 1'b0;
            r_done          <= 1'b0;
            r_aborted       <= 1'b0;
            r_start_ignored <= 1'b0;
        end else begin
            r_state         <= w_state_nxt;
            r_cnt           <= w_cnt_nxt;
            r_period        <= w_period_nxt;
            r_count         <= w_count_nxt;
            r_idx           <= w_idx_nxt;
            r_pulse         <= w_pulse_nxt;
            r_done          <= w_done_nxt;
            r_aborted       <= w_aborted_nxt;
            r_start_ignored <= w_ign_nxt;
        end
    end

    // ---------------------------------------------------------------------
    // Outputs
    // ---------------------------------------------------------------------
    assign pulse_out     = r_pulse;
    assign busy          = (r_state != StIdle);
    assign done          = r_done;
    assign aborted       = r_aborted;
    assign start_ignored = r_start_ignored;
    assign pulse_idx     = r_idx;

    // ---------------------------------------------------------------------
    // Invariants
    // ---------------------------------------------------------------------
    a_done_abort_excl : assert property (@(posedge clkin) disable iff (resetin)
        !(r_done && r_aborted));
    a_end_is_idle : assert property (@(posedge clkin) disable iff (resetin)
        (r_done || r_aborted) |-> (r_state == StIdle));
    a_ign_single : assert property (@(posedge clkin) disable iff (resetin)
        !(r_start_ignored && w_ign_nxt));

endmodule

// File: doc/sync_pulse_gen.md
Name: sync_pulse_gen

Overview:
Programmable strobe generator in the clkin domain, directly upstream of pulse_synchronizer. Produces single-cycle pulses on pulse_out, which drives that synchronizer's sin input. Each run is started by a command and consists of a start delay, then N pulses at a programmable period. Period is clamped to a minimum gap so consecutive pulses never arrive faster than the synchronizer's level/feedback round trip can clear.

Parameters:
pCNT_W, 16, width of cfg_delay, cfg_period, cfg_count and pulse_idx
pMIN_GAP, 8, minimum clkin cycles between pulses; legal range 1 .. 2**pCNT_W-1

Ports:
clkin  input  1  clock
resetin  input  1  asynchronous, active-high reset
start  input  1  run request, sampled each clkin edge
stop  input  1  abort request, sampled each clkin edge
cfg_delay  input  pCNT_W  cycles from accepted start to first pulse (D)
cfg_period  input  pCNT_W  requested pulse spacing (P)
cfg_count  input  pCNT_W  pulses per run (N); 0 = unlimited
pulse_out  output  1  single-cycle strobe, to pulse_synchronizer sin
busy  output  1  run in progress
done  output  1  1-cycle pulse, run completed normally
aborted  output  1  1-cycle pulse, run ended by stop
start_ignored  output  1  1-cycle pulse, start rejected while busy
pulse_idx  output  pCNT_W  pulses emitted in current/last run

Behaviour:
- Reset is resetin: asynchronous, active-high. Clock is clkin.
- All outputs reset to 0. State resets to IDLE. Counters and latched config reset to 0.
- States: IDLE, DELAY, RUN.
- IDLE, start=1 and stop=0 at edge t:
  - Latch D, Peff = max(P, pMIN_GAP), and N.
  - Clear pulse_idx to 0. Go to DELAY.
  - busy=1 from t+1.
- DELAY:
  - Down-counter loaded with D.
  - First pulse_out at cycle t+1+D. D=0 gives a pulse at t+1.
  - Then go to RUN.
- RUN:
  - Gap counter reloaded with Peff-1 on each pulse.
  - Next pulse exactly Peff cycles after the previous one.
  - pulse_idx increments in the same cycle that pulse_out is high (registered; visible next cycle).
- Completion (N>0):
  - After the Nth pulse, the FSM returns to IDLE on the next edge.
  - done=1 and busy=0 in that cycle.
  - pulse_idx holds N until the next accepted start.
- N=0: pulses continue until stop. pulse_idx wraps 2**pCNT_W-1 -> 0 silently.
- stop in DELAY or RUN:
  - IDLE on the next edge; aborted=1 and busy=0 in that cycle.
  - No pulse is emitted on the stop edge, even if one is due (stop wins).
  - done is not asserted. pulse_idx holds its value.
- stop in IDLE: no effect.
- start and stop together in IDLE: stop wins; start is dropped and start_ignored stays 0.
- start while busy: run is unaffected; start_ignored=1 for one cycle.
- cfg_* inputs are only sampled at accepted start; changing them mid-run has no effect.
- resetin mid-run: immediate IDLE, all outputs 0, no done or aborted.
- pulse_out, done, aborted and start_ignored are registered outputs and are never high for 2 consecutive cycles. Exception: pulse_out when Peff=1, which requires pMIN_GAP=1.

Optional Feature:
Macro SYNC_PULSE_GEN_RETRIG_EN.
- Defined: start while busy (stop=0) restarts the run.
  - Re-latch config and clear pulse_idx.
  - Enter DELAY on that edge, with the first pulse D+1 cycles later.
  - Any pulse due on the restart edge is suppressed.
  - start_ignored is tied to 0. done and aborted are not asserted for the interrupted run.
- Undefined: behaviour as in Behaviour (start ignored, start_ignored pulse).

Test Plan:
- D=3, P=10, N=4, start at cycle 0 -> pulse_out at cycles 4, 14, 24, 34. done at 35. busy high 1..34. pulse_idx=4.
- D=0, P=2, N=3, pMIN_GAP=8 -> pulses at 1, 9, 17 (period clamped). done at 18.
- N=0, P=8, stop on cycle of 5th due pulse -> only 4 pulses, aborted=1 that cycle, done never, pulse_idx=4.
- Run active, start pulsed at cycle 12 (macro off) -> pulse schedule unchanged, start_ignored=1 at 13. Macro on -> restart, pulses from 12+1+D.
- Assert resetin mid-DELAY and mid-RUN -> all outputs 0 immediately, no pulse after release until a new start.
- start and stop same cycle in IDLE -> no busy, no pulse, start_ignored=0. pulse_out into pulse_synchronizer gives exactly one sout per pulse.
